// File: rtl/adder_32.sv
// adder_32: multi-cycle IEEE-754 binary32 adder (IDLE/ALIGN/ADD/NORM/ROUND) with round-to-nearest-even.
// Define ADDER_32_SUBNORM_EN for gradual underflow; without it subnormals flush to signed zero.
module adder_32 (
  input  logic        clkn_i,
  input  logic        rstn_i,
  input  logic        valid_i,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Result,
  output logic        done_o
);

`ifdef ADDER_32_SUBNORM_EN
  localparam bit SUBNORM_EN = 1'b1;
`else
  localparam bit SUBNORM_EN = 1'b0;
`endif
  localparam logic [31:0] CANON_NAN = 32'h7FC00000;
  localparam int          SHIFT_SAT = 26;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND} state_t;

  state_t             state_reg;
  logic [31:0]        a_reg;
  logic [31:0]        b_reg;
  logic               sign_reg;
  logic               sub_reg;
  logic               special_reg;
  logic [31:0]        special_val_reg;
  logic signed [9:0]  exp_reg;
  logic [26:0]        big_reg;
  logic [26:0]        small_reg;
  logic [27:0]        sum_reg;
  logic [26:0]        norm_reg;
  logic               zero_reg;
  logic [31:0]        result_reg;
  logic               done_reg;

  // Operand decode, special-value detection and magnitude ordering
  logic        a_sign, b_sign;
  logic [7:0]  a_exp, b_exp, a_eexp, b_eexp;
  logic [22:0] a_frac, b_frac;
  logic [23:0] a_sig, b_sig;
  logic        a_nan, b_nan, a_inf, b_inf, a_larger;
  logic        big_sign;
  logic [7:0]  big_eexp, small_eexp, exp_diff;
  logic [23:0] big_sig, small_sig;
  logic [4:0]  shamt;
  logic        special_next;
  logic [31:0] special_val_next;

  always_comb begin
    a_sign = a_reg[31];
    b_sign = b_reg[31];
    a_exp  = a_reg[30:23];
    b_exp  = b_reg[30:23];
    a_frac = a_reg[22:0];
    b_frac = b_reg[22:0];
    a_nan  = (&a_exp) & (|a_frac);
    b_nan  = (&b_exp) & (|b_frac);
    a_inf  = (&a_exp) & ~(|a_frac);
    b_inf  = (&b_exp) & ~(|b_frac);

    // Subnormals carry exponent 1 with hidden bit 0, or vanish entirely in flush mode
    a_sig  = (a_exp == 8'd0) ? (SUBNORM_EN ? {1'b0, a_frac} : 24'd0) : {1'b1, a_frac};
    b_sig  = (b_exp == 8'd0) ? (SUBNORM_EN ? {1'b0, b_frac} : 24'd0) : {1'b1, b_frac};
    a_eexp = (a_exp == 8'd0) ? 8'd1 : a_exp;
    b_eexp = (b_exp == 8'd0) ? 8'd1 : b_exp;

    // Raw exponent:fraction bits order binary32 magnitudes directly
    a_larger   = (a_reg[30:0] >= b_reg[30:0]);
    big_sign   = a_larger ? a_sign : b_sign;
    big_eexp   = a_larger ? a_eexp : b_eexp;
    small_eexp = a_larger ? b_eexp : a_eexp;
    big_sig    = a_larger ? a_sig  : b_sig;
    small_sig  = a_larger ? b_sig  : a_sig;
    exp_diff   = big_eexp - small_eexp;
    shamt      = (exp_diff > 8'(SHIFT_SAT)) ? 5'(SHIFT_SAT) : exp_diff[4:0];

    special_next = a_nan | b_nan | a_inf | b_inf;
    if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign))) begin
      special_val_next = CANON_NAN;
    end else if (a_inf) begin
      special_val_next = {a_sign, 8'hFF, 23'd0};
    end else begin
      special_val_next = {b_sign, 8'hFF, 23'd0};
    end
  end

  // Logarithmic right shifter; every bit dropped off the bottom folds into sticky
  logic [26:0] shift_val    [0:5];
  logic        shift_sticky [0:5];
  logic [26:0] aligned_small;

  assign shift_val[0]    = {small_sig, 3'b000};
  assign shift_sticky[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_align_shift
      localparam int SH = 1 << gi;
      assign shift_val[gi+1]    = shamt[gi] ? (shift_val[gi] >> SH) : shift_val[gi];
      assign shift_sticky[gi+1] = shift_sticky[gi] | (shamt[gi] & (|shift_val[gi][SH-1:0]));
    end
  endgenerate

  assign aligned_small = {shift_val[5][26:1], shift_val[5][0] | shift_sticky[5]};

  // Magnitude add/subtract; big_reg never falls below small_reg after alignment
  logic [27:0] sum_next;
  assign sum_next = sub_reg ? ({1'b0, big_reg} - {1'b0, small_reg})
                            : ({1'b0, big_reg} + {1'b0, small_reg});

  // Normalisation: leading-zero priority encoder and single-cycle left shift
  logic signed [9:0] lz;
  logic signed [9:0] lim;
  logic signed [9:0] shl;
  logic signed [9:0] norm_exp_next;
  logic [26:0]       norm_next;

  always_comb begin
    lz = '0;
    for (int i = 0; i < 27; i++) begin
      if (sum_reg[i]) lz = 10'(26 - i);
    end
    // With gradual underflow the exponent must not drop below 1
    lim = exp_reg - 10'sd1;
    shl = (SUBNORM_EN && (lz > lim)) ? lim : lz;
    if (sum_reg[27]) begin
      norm_next     = {sum_reg[27:2], sum_reg[1] | sum_reg[0]};
      norm_exp_next = exp_reg + 10'sd1;
    end else begin
      norm_next     = sum_reg[26:0] << shl;
      norm_exp_next = exp_reg - shl;
    end
  end

  // Rounding, overflow to infinity, underflow handling and final packing
  logic [23:0]       mant;
  logic [23:0]       fmant;
  logic [24:0]       rmant;
  logic              round_up;
  logic signed [9:0] fexp;
  logic [7:0]        enc_exp;
  logic [31:0]       result_next;

  always_comb begin
    mant     = norm_reg[26:3];
    round_up = norm_reg[2] & (norm_reg[1] | norm_reg[0] | mant[0]);
    rmant    = {1'b0, mant} + {24'd0, round_up};
    if (rmant[24]) begin
      fmant = rmant[24:1];
      fexp  = exp_reg + 10'sd1;
    end else begin
      fmant = rmant[23:0];
      fexp  = exp_reg;
    end
    // A clear hidden bit after rounding means the result is subnormal
    enc_exp = fmant[23] ? fexp[7:0] : 8'd0;

    if (special_reg) begin
      result_next = special_val_reg;
    end else if (zero_reg) begin
      result_next = {sign_reg & ~sub_reg, 31'd0};
    end else if (fexp >= 10'sd255) begin
      result_next = {sign_reg, 8'hFF, 23'd0};
    end else if (!SUBNORM_EN && (fexp < 10'sd1)) begin
      result_next = {sign_reg, 31'd0};
    end else begin
      result_next = {sign_reg, enc_exp, fmant[22:0]};
    end
  end

  always_ff @(posedge clkn_i) begin
    if (rstn_i) begin
      state_reg       <= IDLE;
      a_reg           <= '0;
      b_reg           <= '0;
      sign_reg        <= 1'b0;
      sub_reg         <= 1'b0;
      special_reg     <= 1'b0;
      special_val_reg <= '0;
      exp_reg         <= '0;
      big_reg         <= '0;
      small_reg       <= '0;
      sum_reg         <= '0;
      norm_reg        <= '0;
      zero_reg        <= 1'b0;
      result_reg      <= '0;
      done_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (valid_i) begin
            a_reg     <= A;
            b_reg     <= B;
            state_reg <= ALIGN;
          end
        end
        ALIGN: begin
          big_reg         <= {big_sig, 3'b000};
          small_reg       <= aligned_small;
          exp_reg         <= $signed({2'b00, big_eexp});
          sign_reg        <= big_sign;
          sub_reg         <= a_sign ^ b_sign;
          special_reg     <= special_next;
          special_val_reg <= special_val_next;
          state_reg       <= ADD;
        end
        ADD: begin
          sum_reg   <= sum_next;
          state_reg <= NORM;
        end
        NORM: begin
          norm_reg  <= norm_next;
          exp_reg   <= norm_exp_next;
          zero_reg  <= (sum_reg == 28'd0);
          state_reg <= ROUND;
        end
        ROUND: begin
          result_reg <= result_next;
          done_reg   <= 1'b1;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign Result = result_reg;
  assign done_o = done_reg;

endmodule

// File: tb/tb_adder_32.sv
// tb_adder_32: directed vectors for adder_32, checked against an exact-arithmetic reference model.
// Honours ADDER_32_SUBNORM_EN the same way the design does.
`timescale 1ns/1ps
module tb_adder_32;

  logic        clkn_i = 1'b0;
  logic        rstn_i;
  logic        valid_i;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Result;
  logic        done_o;

  adder_32 dut (
    .clkn_i (clkn_i),
    .rstn_i (rstn_i),
    .valid_i(valid_i),
    .A      (A),
    .B      (B),
    .Result (Result),
    .done_o (done_o)
  );

  always #5 clkn_i = ~clkn_i;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    int          due;
    logic [31:0] val;
  } pend_t;

  pend_t       pend_q[$];
  pend_t       new_p;
  int          edge_cnt    = 0;
  logic [31:0] held_result = 32'd0;
  bit          cmp_en      = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
  endtask

  // Exact fixed-point value in units of 2^-149
  function automatic logic [287:0] to_fixed(input logic [7:0] e, input logic [22:0] f);
    logic [287:0] v;
    v = '0;
    if (e == 8'd0) begin
`ifdef ADDER_32_SUBNORM_EN
      v[22:0] = f;
`endif
    end else begin
      v[23:0] = {1'b1, f};
      v = v << (e - 8'd1);
    end
    return v;
  endfunction

  // Exact sum, then a single round-to-nearest-even to 24 significant bits
  function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
    logic         sa, sb, s, up;
    logic [7:0]   ea, eb;
    logic [22:0]  fa, fb;
    logic [287:0] ma, mb, m, q, rem, half, mask;
    int           p, lsb, e;
    sa = a[31]; ea = a[30:23]; fa = a[22:0];
    sb = b[31]; eb = b[30:23]; fb = b[22:0];
    if ((ea == 8'hFF && fa != 23'd0) || (eb == 8'hFF && fb != 23'd0)) return 32'h7FC00000;
    if (ea == 8'hFF && eb == 8'hFF) return (sa == sb) ? a : 32'h7FC00000;
    if (ea == 8'hFF) return a;
    if (eb == 8'hFF) return b;
    ma = to_fixed(ea, fa);
    mb = to_fixed(eb, fb);
    if (sa == sb) begin
      m = ma + mb; s = sa;
    end else if (ma >= mb) begin
      m = ma - mb; s = sa;
    end else begin
      m = mb - ma; s = sb;
    end
    if (m == '0) return (sa == sb) ? {sa, 31'd0} : 32'd0;
    p = 0;
    for (int i = 0; i < 288; i++) if (m[i]) p = i;
    lsb = p - 23;
    if (lsb < 0) begin
`ifdef ADDER_32_SUBNORM_EN
      lsb = 0;
`else
      return {s, 31'd0};
`endif
    end
    q    = m >> lsb;
    mask = (288'd1 << lsb) - 288'd1;
    rem  = m & mask;
    half = (lsb > 0) ? (288'd1 << (lsb - 1)) : 288'd0;
    up   = (lsb > 0) && ((rem > half) || ((rem == half) && q[0]));
    q    = q + {287'd0, up};
    if (q[24]) begin
      q   = q >> 1;
      lsb = lsb + 1;
    end
    e = q[23] ? lsb + 1 : 0;
    if (e >= 255) return {s, 8'hFF, 23'd0};
    return {s, e[7:0], q[22:0]};
  endfunction

  // Transaction acceptance: one operation in flight, reset wins over valid
  always @(posedge clkn_i) begin
    edge_cnt++;
    if (rstn_i === 1'b1) begin
      pend_q.delete();
      held_result = 32'd0;
    end else if (valid_i === 1'b1 && !(pend_q.size() > 0 && pend_q[$].due >= edge_cnt)) begin
      new_p.due = edge_cnt + 4;
      new_p.val = model_add(A, B);
      pend_q.push_back(new_p);
    end
  end

  // Cycle-by-cycle comparison of done_o and Result against the model
  always @(negedge clkn_i) begin
    if (cmp_en) begin
      if (pend_q.size() > 0 && pend_q[0].due == edge_cnt) begin
        check("cmp_done", {31'd0, done_o}, 32'd1);
        check("cmp_result", Result, pend_q[0].val);
        held_result = pend_q[0].val;
        void'(pend_q.pop_front());
      end else begin
        check("cmp_done", {31'd0, done_o}, 32'd0);
        check("cmp_hold", Result, held_result);
      end
    end
  end

  task automatic wait_done(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clkn_i);
      if (done_o) seen = 1'b1;
    end
    check({nm, "_done_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic run_vec(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string nm);
    check({nm, "_model"}, model_add(a, b), exp);
    @(negedge clkn_i);
    A = a; B = b; valid_i = 1'b1;
    @(negedge clkn_i);
    valid_i = 1'b0;
    wait_done(nm);
    check(nm, Result, exp);
    $display("txn %s: %08h + %08h -> %08h (want %08h)", nm, a, b, Result, exp);
  endtask

  initial begin
    int pulses;
    rstn_i = 1'b1; valid_i = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clkn_i);
    cmp_en = 1'b1;
    check("reset_result", Result, 32'd0);
    check("reset_done", {31'd0, done_o}, 32'd0);
    rstn_i = 1'b0;

    run_vec(32'h00000000, 32'h00000000, 32'h00000000, "zero_zero");
    run_vec(32'h3F800000, 32'h3F988D00, 32'h400C4680, "sum_carry");
    run_vec(32'h3638EF1D, 32'hB5B8EF1C, 32'h35B8EF1E, "sum_cancel");
    run_vec(32'h2317A4DB, 32'h00000000, 32'h2317A4DB, "sum_plus_zero");
    run_vec(32'h3F800000, 32'h33800000, 32'h3F800000, "tie_even");
    run_vec(32'h3F800001, 32'h33800000, 32'h3F800002, "tie_up");
    run_vec(32'h4B800000, 32'h3F800000, 32'h4B800000, "tie_big");
    run_vec(32'h3F800000, 32'hB3800000, 32'h3F7FFFFF, "borrow_far");
    run_vec(32'h40000000, 32'hC0400000, 32'hBF800000, "neg_result");
    run_vec(32'h7F800000, 32'hFF800000, 32'h7FC00000, "inf_minus_inf");
    run_vec(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, "overflow_pos");
    run_vec(32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000, "overflow_neg");
    run_vec(32'h3F800000, 32'hBF800000, 32'h00000000, "exact_cancel");
    run_vec(32'h80000000, 32'h80000000, 32'h80000000, "negz_negz");
    run_vec(32'h00000000, 32'h80000000, 32'h00000000, "posz_negz");
    run_vec(32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan_operand");
    run_vec(32'hFF800000, 32'h42000000, 32'hFF800000, "inf_plus_finite");
    run_vec(32'h7F800000, 32'h7F800000, 32'h7F800000, "inf_plus_inf");
`ifdef ADDER_32_SUBNORM_EN
    run_vec(32'h00000001, 32'h00000001, 32'h00000002, "subnorm_tiny");
    run_vec(32'h00400000, 32'h00400000, 32'h00800000, "subnorm_to_norm");
    run_vec(32'h00800000, 32'h80400000, 32'h00400000, "norm_to_subnorm");
`else
    run_vec(32'h00000001, 32'h00000001, 32'h00000000, "subnorm_tiny");
    run_vec(32'h00400000, 32'h00400000, 32'h00000000, "subnorm_to_norm");
    run_vec(32'h00800000, 32'h80400000, 32'h00800000, "norm_to_subnorm");
`endif

    // A new operation presented in the done_o cycle is accepted
    @(negedge clkn_i);
    A = 32'h3F800000; B = 32'h3F800000; valid_i = 1'b1;
    @(negedge clkn_i);
    valid_i = 1'b0;
    wait_done("b2b_first");
    check("b2b_first", Result, 32'h40000000);
    A = 32'h40000000; B = 32'hC0400000; valid_i = 1'b1;
    @(negedge clkn_i);
    valid_i = 1'b0;
    wait_done("b2b_second");
    check("b2b_second", Result, 32'hBF800000);
    $display("txn b2b: second result %08h", Result);

    // valid_i during ALIGN is ignored
    @(negedge clkn_i);
    A = 32'h3F800000; B = 32'h3F988D00; valid_i = 1'b1;
    @(negedge clkn_i);
    A = 32'h7F800000; B = 32'hFF800000;
    @(negedge clkn_i);
    valid_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clkn_i);
      if (done_o) pulses++;
    end
    check("align_ignore_pulses", 32'(pulses), 32'd1);
    check("align_ignore_result", Result, 32'h400C4680);
    $display("txn align_ignore: %0d pulse(s), result %08h", pulses, Result);

    // Reset during NORM aborts; reset also wins over a simultaneous valid_i
    @(negedge clkn_i);
    A = 32'h3F800000; B = 32'h3F988D00; valid_i = 1'b1;
    @(negedge clkn_i);
    valid_i = 1'b0;
    @(negedge clkn_i);
    @(negedge clkn_i);
    rstn_i = 1'b1; valid_i = 1'b1; A = 32'h3F800000; B = 32'h3F800000;
    @(negedge clkn_i);
    rstn_i = 1'b0; valid_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clkn_i);
      if (done_o) pulses++;
    end
    check("abort_pulses", 32'(pulses), 32'd0);
    check("abort_result", Result, 32'd0);
    $display("txn reset_in_norm: %0d pulse(s), result %08h", pulses, Result);

    run_vec(32'h3F800000, 32'h3F988D00, 32'h400C4680, "after_reset");

    repeat (2) @(negedge clkn_i);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/adder_32.md
ADDER_32 -- requirements
Module: adder_32

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clkn_i and rstn_i as the codebase does.
REQ-002 clkn_i  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rstn_i  input  1  synchronous reset; active-high despite the "n" in the name.
REQ-004 valid_i  input  1  start strobe; A and B are valid when high.
REQ-005 A  input  32  IEEE-754 binary32 operand.
REQ-006 B  input  32  IEEE-754 binary32 operand.
REQ-007 Result  output  32  registered binary32 sum A+B.
REQ-008 done_o  output  1  one-cycle pulse; Result is valid when high.

Function
REQ-009 FSM states: IDLE, ALIGN, ADD, NORM, ROUND; IDLE is the reset state.
REQ-010 IDLE with valid_i=1 at an edge: latch A and B, go to ALIGN.
- valid_i is ignored in every non-IDLE state; no queuing.
REQ-011 Transitions: ALIGN -> ADD -> NORM -> ROUND -> IDLE, one state per cycle.
- On the ROUND edge, Result is registered and done_o=1 for exactly one cycle.
- Latency: done_o rises 4 edges after the capture edge.
REQ-012 Result SHALL hold its value until the next done_o pulse; done_o=0 at all other times.
REQ-013 A valid_i sampled in the cycle done_o=1 SHALL be accepted, since the FSM is then in IDLE.
REQ-014 ALIGN: the smaller-exponent significand is right-shifted by the exponent difference.
- Shift saturates at 26 places.
- Guard, round and sticky bits are kept.
REQ-015 ADD: equal signs add magnitudes; unequal signs subtract smaller from larger magnitude.
- Result sign is the sign of the larger magnitude.
REQ-016 NORM: 1-bit right shift on carry-out, or left shift by the leading-zero count.
- The left shift is a combinational priority encoder in a single cycle.
REQ-017 ROUND: round-to-nearest, ties-to-even.
- A mantissa carry-out from rounding increments the exponent.
REQ-018 Exact cancellation x+(-x) SHALL give +0 (00000000).
- (+0)+(+0)=+0; (-0)+(-0)=-0; (+0)+(-0)=+0.
REQ-019 Any NaN operand, or inf+(-inf), SHALL give canonical NaN 7FC00000.
REQ-020 inf plus a finite value SHALL give that inf; inf plus inf of the same sign SHALL give that inf.
REQ-021 Exponent overflow after rounding SHALL give signed infinity (7F800000 / FF800000).
REQ-022 Special cases are detected in ALIGN and bypass the arithmetic, but the 4-cycle latency is kept.

Reset
REQ-023 rstn_i=1 at an edge SHALL set: state=IDLE, Result=00000000, done_o=0, all internal registers=0.
REQ-024 Reset in the middle of an operation SHALL abort it; no done_o pulse is produced for the aborted operation.
REQ-025 Reset has priority over valid_i in the same cycle.

Configuration
REQ-026 Macro ADDER_32_SUBNORM_EN defined: full gradual-underflow support.
- Subnormal inputs use hidden bit 0 and exponent 1.
- Results below the normal range are rounded to subnormals.
REQ-027 Macro undefined: flush-to-zero.
- Subnormal inputs are treated as signed zero.
- Subnormal or underflowing results become signed zero.
REQ-028 Interface and latency SHALL be identical in both builds.

Verification
REQ-029 A=00000000, B=00000000, pulse valid_i -> done_o 4 cycles later, Result=00000000.
REQ-030 Sum cases:
- 3F800000+3F988D00 -> 400C4680.
- 3638EF1D+B5B8EF1C -> 35B8EF1E.
- 2317A4DB+00000000 -> 2317A4DB.
REQ-031 Rounding cases:
- 3F800000+33800000 -> 3F800000 (tie, stays even).
- 3F800001+33800000 -> 3F800002 (tie, rounds up to even).
REQ-032 Special values:
- 7F800000+FF800000 -> 7FC00000.
- 7F7FFFFF+7F7FFFFF -> 7F800000.
- 3F800000+BF800000 -> 00000000.
REQ-033 Subnormal case 00000001+00000001 -> 00000002 with ADDER_32_SUBNORM_EN; 00000000 without it.
REQ-034 Control cases:
- valid_i pulsed during ALIGN: ignored; single done_o pulse.
- rstn_i during NORM: no done_o; Result=00000000.
